// File: rtl/axil_bridge_pkg.sv
// rtl/axil_bridge_pkg.sv - shared types, constants and helpers for the reg-to-AXI-Lite bridge
package axil_bridge_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 32;
    localparam int unsigned REG_DATA_WIDTH = 32;

    localparam logic [2:0] DEFAULT_PROT = 3'b000;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0]   addr;
        logic                        write;
        logic [REG_DATA_WIDTH-1:0]   wdata;
        logic [REG_DATA_WIDTH/8-1:0] wstrb;
        logic                        valid;
    } reg_req_t;

    typedef struct packed {
        logic [REG_DATA_WIDTH-1:0] rdata;
        logic                      error;
        logic                      ready;
    } reg_rsp_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_if.sv
// rtl/axil_if.sv - AXI-Lite channel bundle with master and slave views
interface AXI_LITE #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]                  aw_prot;
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_valid;
    logic                        w_ready;
    logic [1:0]                  b_resp;
    logic                        b_valid;
    logic                        b_ready;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]                  ar_prot;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport Slave (
        input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/axil_timeout_cnt.sv
// rtl/axil_timeout_cnt.sv - saturating wait counter flagging when a transaction has waited too long
module axil_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired_o = 1'b0;
        end else begin : g_on
            localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);
            logic [31:0] count_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    count_q <= '0;
                end else if (clear_i) begin
                    count_q <= '0;
                end else if (en_i && (count_q != '1)) begin
                    count_q <= count_q + 32'd1;
                end
            end

            assign expired_o = en_i && (count_q >= LIMIT);
        end
    endgenerate

endmodule

// File: rtl/axil_reg_master_bridge.sv
// rtl/axil_reg_master_bridge.sv - one-at-a-time bridge from reg_req/reg_rsp structs to an AXI-Lite master
module axil_reg_master_bridge
    import axil_bridge_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [2:0]  AXI_PROT       = DEFAULT_PROT,
    parameter type         req_t          = reg_req_t,
    parameter type         rsp_t          = reg_rsp_t
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  req_t    reg_req_i,
    output rsp_t    reg_rsp_o,
    AXI_LITE.Master axil_if,
    output logic    busy_o,
    output logic    timeout_o
);

    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    state_e                    state_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     wstrb_q;
    logic                      write_q;
    logic                      aw_valid_q, w_valid_q, ar_valid_q;
    logic                      b_ready_q, r_ready_q;
    logic                      aw_done_q, w_done_q;
    logic                      drain_q;
    logic                      rsp_ready_q, rsp_error_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic                      busy_q, timeout_q;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic cnt_wait, cnt_en, expired, tmo_fire;

    assign aw_hs = aw_valid_q && axil_if.aw_ready;
    assign w_hs  = w_valid_q  && axil_if.w_ready;
    assign ar_hs = ar_valid_q && axil_if.ar_ready;
    assign b_hs  = b_ready_q  && axil_if.b_valid;
    assign r_hs  = r_ready_q  && axil_if.r_valid;

    // The accept cycle is counted too, so expiry lands TIMEOUT_CYCLES cycles after the request.
    assign cnt_wait = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
                      (state_q == RD_ADDR) || (state_q == RD_DATA);
    assign cnt_en   = cnt_wait || ((state_q == IDLE) && reg_req_i.valid);
    assign tmo_fire = expired && cnt_wait && !b_hs && !r_hs;

    axil_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!cnt_en),
        .en_i      (cnt_en),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            drain_q     <= 1'b0;
            rsp_ready_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            rsp_ready_q <= 1'b0;
            timeout_q   <= 1'b0;
            // Address/data valids fall after their own handshake in any state, DRAIN included.
            if (aw_hs) aw_valid_q <= 1'b0;
            if (w_hs)  w_valid_q  <= 1'b0;
            if (ar_hs) ar_valid_q <= 1'b0;

            if (tmo_fire) begin
                state_q     <= RESP;
                rsp_ready_q <= 1'b1;
                rsp_error_q <= 1'b1;
                rdata_q     <= '0;
                timeout_q   <= 1'b1;
                drain_q     <= 1'b1;
                b_ready_q   <= 1'b0;
                r_ready_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (reg_req_i.valid) begin
                            addr_q    <= reg_req_i.addr;
                            wdata_q   <= reg_req_i.wdata;
                            wstrb_q   <= reg_req_i.wstrb;
                            write_q   <= reg_req_i.write;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            busy_q    <= 1'b1;
                            if (reg_req_i.write) begin
                                aw_valid_q <= 1'b1;
                                w_valid_q  <= 1'b1;
                                state_q    <= WR_ADDR_DATA;
                            end else begin
                                ar_valid_q <= 1'b1;
                                state_q    <= RD_ADDR;
                            end
                        end
                    end
                    WR_ADDR_DATA: begin
                        aw_done_q <= aw_done_q || aw_hs;
                        w_done_q  <= w_done_q || w_hs;
                        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                            b_ready_q <= 1'b1;
                            state_q   <= WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        if (b_hs) begin
                            b_ready_q   <= 1'b0;
                            rsp_error_q <= resp_is_err(axil_if.b_resp);
                            rdata_q     <= '0;
                            rsp_ready_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                    RD_ADDR: begin
                        if (ar_hs) begin
                            r_ready_q <= 1'b1;
                            state_q   <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (r_hs) begin
                            r_ready_q   <= 1'b0;
                            rsp_error_q <= resp_is_err(axil_if.r_resp);
                            rdata_q     <= axil_if.r_data;
                            rsp_ready_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                    RESP: begin
                        if (drain_q) begin
                            b_ready_q <= write_q;
                            r_ready_q <= !write_q;
                            state_q   <= DRAIN;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (write_q ? b_hs : r_hs) begin
                            b_ready_q <= 1'b0;
                            r_ready_q <= 1'b0;
                            drain_q   <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign axil_if.aw_addr  = addr_q;
    assign axil_if.aw_prot  = AXI_PROT;
    assign axil_if.aw_valid = aw_valid_q;
    assign axil_if.w_data   = wdata_q;
    assign axil_if.w_strb   = wstrb_q;
    assign axil_if.w_valid  = w_valid_q;
    assign axil_if.b_ready  = b_ready_q;
    assign axil_if.ar_addr  = addr_q;
    assign axil_if.ar_prot  = AXI_PROT;
    assign axil_if.ar_valid = ar_valid_q;
    assign axil_if.r_ready  = r_ready_q;

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = rsp_error_q;
        reg_rsp_o.ready = rsp_ready_q;
    end

    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule
